// File: rtl/pipelined_control_unit.sv
// ID/EX control stage: decodes class flags + funct into a registered control bundle and
// holds EX for multi-cycle MULT/DIV. Define PCU_ILLEGAL_TRAP_EN to add the o_illegal pulse.
module pipelined_control_unit #(
  parameter int MUL_LATENCY = 4,
  parameter int DIV_LATENCY = 8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_valid,
  input  logic [5:0] i_funct,
  input  logic       i_flg_pc_modify,
  input  logic       i_flg_link_ret,
  input  logic       i_flg_inmediate,
  input  logic       i_flg_mem_op,
  input  logic       i_flg_mem_type,
  input  logic [1:0] i_flg_addr_type,
  input  logic       i_hazard_detected,
  input  logic       i_flush,
  output logic       o_valid,
  output logic [1:0] o_flg_ALU_src_a,
  output logic       o_flg_ALU_src_b,
  output logic [1:0] o_flg_ALU_dst,
  output logic [3:0] o_ALU_opcode,
  output logic       o_flg_AGU_src_addr,
  output logic [2:0] o_flg_AGU_opcode,
  output logic       o_flg_jump,
  output logic       o_flg_branch,
  output logic       o_flg_reg_wr_en,
  output logic       o_flg_mem_wr_en,
  output logic       o_flg_wb_src,
  output logic       o_flg_jmp_trg_reg,
  output logic [1:0] o_extend_sign,
  output logic       o_ex_hold,
  output logic       o_stall_req
`ifdef PCU_ILLEGAL_TRAP_EN
  ,
  output logic       o_illegal
`endif
);

  localparam int MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LATENCY - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LATENCY - 1);

  localparam logic [3:0] OP_SRL  = 4'b0000, OP_SLL = 4'b0001, OP_SRA = 4'b0010;
  localparam logic [3:0] OP_PASS = 4'b0011, OP_ADD = 4'b0100, OP_SUB = 4'b0101;
  localparam logic [3:0] OP_AND  = 4'b0110, OP_OR  = 4'b0111, OP_XOR = 4'b1000;
  localparam logic [3:0] OP_NOR  = 4'b1001, OP_SLT = 4'b1010, OP_CMP = 4'b1011;
  localparam logic [3:0] OP_SADD = 4'b1100, OP_MUL = 4'b1101, OP_DIV = 4'b1110;

  typedef struct packed {
    logic [1:0] src_a;
    logic       src_b;
    logic [1:0] dst;
    logic [3:0] alu_op;
    logic       agu_src;
    logic [2:0] agu_op;
    logic       jump;
    logic       branch;
    logic       wr_en;
    logic       mem_wr_en;
    logic       wb_src;
    logic       jmp_trg_reg;
    logic [1:0] ext;
  } ctrl_t;

  typedef enum logic {S_IDLE, S_MULTI} state_t;

  ctrl_t            ctrl_d, ctrl_q;
  logic             dec_ok_d, dec_multi_d;
  logic [CNT_W-1:0] dec_cnt_d, cnt_q;
  logic             valid_q;
  state_t           state_q;
  logic [5:0]       key;

  assign key = {i_flg_pc_modify, i_flg_link_ret, i_flg_addr_type, i_flg_inmediate, i_flg_mem_op};

  always_comb begin
    ctrl_d      = '0;
    dec_ok_d    = 1'b1;
    dec_multi_d = 1'b0;
    dec_cnt_d   = '0;
    casez (key)
      6'b0???0?: begin
        ctrl_d.src_a  = 2'b01;
        ctrl_d.dst    = 2'b01;
        ctrl_d.wr_en  = 1'b1;
        ctrl_d.wb_src = 1'b1;
        case (i_funct)
          6'b000000: begin ctrl_d.alu_op = OP_SLL; ctrl_d.src_b = 1'b1; end
          6'b000010: begin ctrl_d.alu_op = OP_SRL; ctrl_d.src_b = 1'b1; end
          6'b000011: begin ctrl_d.alu_op = OP_SRA; ctrl_d.src_b = 1'b1; end
          6'b000100: ctrl_d.alu_op = OP_SLL;
          6'b000110: ctrl_d.alu_op = OP_SRL;
          6'b000111: ctrl_d.alu_op = OP_SRA;
          6'b100000, 6'b100001: ctrl_d.alu_op = OP_ADD;
          6'b100010, 6'b100011: ctrl_d.alu_op = OP_SUB;
          6'b100100: ctrl_d.alu_op = OP_AND;
          6'b100101: ctrl_d.alu_op = OP_OR;
          6'b100110: ctrl_d.alu_op = OP_XOR;
          6'b100111: ctrl_d.alu_op = OP_NOR;
          6'b101010, 6'b101011: ctrl_d.alu_op = OP_SLT;
          6'b011000: begin ctrl_d.alu_op = OP_MUL; dec_multi_d = 1'b1; dec_cnt_d = MUL_CNT; end
          6'b011010: begin ctrl_d.alu_op = OP_DIV; dec_multi_d = 1'b1; dec_cnt_d = DIV_CNT; end
          default:   dec_ok_d = 1'b0;
        endcase
      end
      6'b100000, 6'b110000: begin
        ctrl_d.jump        = 1'b1;
        ctrl_d.jmp_trg_reg = 1'b1;
        if (i_flg_link_ret) begin
          ctrl_d.alu_op = OP_PASS;
          ctrl_d.dst    = 2'b01;
          ctrl_d.wr_en  = 1'b1;
          ctrl_d.wb_src = 1'b1;
        end
      end
      6'b000011: begin
        ctrl_d.agu_op    = 3'b001;
        ctrl_d.alu_op    = OP_PASS;
        ctrl_d.src_a     = 2'b01;
        ctrl_d.mem_wr_en = i_flg_mem_type;
        ctrl_d.wr_en     = ~i_flg_mem_type;
        ctrl_d.wb_src    = i_flg_mem_type;
      end
      6'b000010: begin
        ctrl_d.src_a  = 2'b11;
        ctrl_d.wr_en  = 1'b1;
        ctrl_d.wb_src = 1'b1;
        case (i_funct[2:0])
          3'b000:  ctrl_d.alu_op = OP_SADD;
          3'b100:  ctrl_d.alu_op = OP_AND;
          3'b101:  ctrl_d.alu_op = OP_OR;
          3'b110:  ctrl_d.alu_op = OP_XOR;
          3'b010:  ctrl_d.alu_op = OP_SLT;
          3'b111:  begin ctrl_d.alu_op = OP_PASS; ctrl_d.ext = 2'b10; end
          default: dec_ok_d = 1'b0;
        endcase
      end
      6'b101010: begin
        ctrl_d.alu_op  = OP_CMP;
        ctrl_d.src_a   = 2'b01;
        ctrl_d.branch  = 1'b1;
        ctrl_d.agu_src = 1'b1;
        ctrl_d.agu_op  = 3'b010;
      end
      6'b1?0100: begin
        ctrl_d.dst     = 2'b11;
        ctrl_d.alu_op  = OP_PASS;
        ctrl_d.agu_src = 1'b1;
        ctrl_d.agu_op  = 3'b011;
        ctrl_d.jump    = 1'b1;
        ctrl_d.wr_en   = i_flg_link_ret;
        ctrl_d.wb_src  = 1'b1;
      end
      default: dec_ok_d = 1'b0;
    endcase
  end

  // Bubbles clear only the side-effecting bits; the rest of the bundle is left as it was.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ctrl_q  <= '0;
`ifdef PCU_ILLEGAL_TRAP_EN
      o_illegal <= 1'b0;
`endif
    end else begin
`ifdef PCU_ILLEGAL_TRAP_EN
      o_illegal <= 1'b0;
`endif
      if (i_flush) begin
        state_q          <= S_IDLE;
        cnt_q            <= '0;
        valid_q          <= 1'b0;
        ctrl_q.jump      <= 1'b0;
        ctrl_q.branch    <= 1'b0;
        ctrl_q.wr_en     <= 1'b0;
        ctrl_q.mem_wr_en <= 1'b0;
      end else if (state_q == S_MULTI) begin
        if (cnt_q == CNT_W'(1)) state_q <= S_IDLE;
        cnt_q <= cnt_q - 1'b1;
      end else if (i_hazard_detected || !i_valid || !dec_ok_d) begin
        valid_q          <= 1'b0;
        ctrl_q.jump      <= 1'b0;
        ctrl_q.branch    <= 1'b0;
        ctrl_q.wr_en     <= 1'b0;
        ctrl_q.mem_wr_en <= 1'b0;
`ifdef PCU_ILLEGAL_TRAP_EN
        o_illegal <= i_valid && !i_hazard_detected && !dec_ok_d;
`endif
      end else begin
        valid_q <= 1'b1;
        ctrl_q  <= ctrl_d;
        if (dec_multi_d && dec_cnt_d != '0) begin
          state_q <= S_MULTI;
          cnt_q   <= dec_cnt_d;
        end
      end
    end
  end

  assign o_valid            = valid_q;
  assign o_flg_ALU_src_a    = ctrl_q.src_a;
  assign o_flg_ALU_src_b    = ctrl_q.src_b;
  assign o_flg_ALU_dst      = ctrl_q.dst;
  assign o_ALU_opcode       = ctrl_q.alu_op;
  assign o_flg_AGU_src_addr = ctrl_q.agu_src;
  assign o_flg_AGU_opcode   = ctrl_q.agu_op;
  assign o_flg_jump         = ctrl_q.jump;
  assign o_flg_branch       = ctrl_q.branch;
  assign o_flg_reg_wr_en    = ctrl_q.wr_en;
  assign o_flg_mem_wr_en    = ctrl_q.mem_wr_en;
  assign o_flg_wb_src       = ctrl_q.wb_src;
  assign o_flg_jmp_trg_reg  = ctrl_q.jmp_trg_reg;
  assign o_extend_sign      = ctrl_q.ext;
  assign o_ex_hold          = (state_q == S_MULTI);
  assign o_stall_req        = (state_q == S_MULTI);

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed testbench for pipelined_control_unit (default latencies MUL=4, DIV=8).
module tb_pipelined_control_unit;

  logic       i_clk, i_reset, i_valid;
  logic [5:0] i_funct;
  logic       i_flg_pc_modify, i_flg_link_ret, i_flg_inmediate, i_flg_mem_op, i_flg_mem_type;
  logic [1:0] i_flg_addr_type;
  logic       i_hazard_detected, i_flush;
  logic       o_valid;
  logic [1:0] o_flg_ALU_src_a;
  logic       o_flg_ALU_src_b;
  logic [1:0] o_flg_ALU_dst;
  logic [3:0] o_ALU_opcode;
  logic       o_flg_AGU_src_addr;
  logic [2:0] o_flg_AGU_opcode;
  logic       o_flg_jump, o_flg_branch, o_flg_reg_wr_en, o_flg_mem_wr_en, o_flg_wb_src, o_flg_jmp_trg_reg;
  logic [1:0] o_extend_sign;
  logic       o_ex_hold, o_stall_req;
`ifdef PCU_ILLEGAL_TRAP_EN
  logic       o_illegal;
`endif

  int checks = 0;
  int failures = 0;

  pipelined_control_unit dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_funct(i_funct),
    .i_flg_pc_modify(i_flg_pc_modify), .i_flg_link_ret(i_flg_link_ret),
    .i_flg_inmediate(i_flg_inmediate), .i_flg_mem_op(i_flg_mem_op),
    .i_flg_mem_type(i_flg_mem_type), .i_flg_addr_type(i_flg_addr_type),
    .i_hazard_detected(i_hazard_detected), .i_flush(i_flush),
    .o_valid(o_valid), .o_flg_ALU_src_a(o_flg_ALU_src_a), .o_flg_ALU_src_b(o_flg_ALU_src_b),
    .o_flg_ALU_dst(o_flg_ALU_dst), .o_ALU_opcode(o_ALU_opcode),
    .o_flg_AGU_src_addr(o_flg_AGU_src_addr), .o_flg_AGU_opcode(o_flg_AGU_opcode),
    .o_flg_jump(o_flg_jump), .o_flg_branch(o_flg_branch), .o_flg_reg_wr_en(o_flg_reg_wr_en),
    .o_flg_mem_wr_en(o_flg_mem_wr_en), .o_flg_wb_src(o_flg_wb_src),
    .o_flg_jmp_trg_reg(o_flg_jmp_trg_reg), .o_extend_sign(o_extend_sign),
    .o_ex_hold(o_ex_hold), .o_stall_req(o_stall_req)
`ifdef PCU_ILLEGAL_TRAP_EN
    , .o_illegal(o_illegal)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic drive(input logic v, input logic [5:0] key, input logic mt, input logic [5:0] fn);
    i_valid = v;
    {i_flg_pc_modify, i_flg_link_ret, i_flg_addr_type, i_flg_inmediate, i_flg_mem_op} = key;
    i_flg_mem_type = mt;
    i_funct = fn;
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_hazard_detected = 1'b0; i_flush = 1'b0;
    drive(1'b0, 6'b000000, 1'b0, 6'b000000);
    step(); step();
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", o_valid); end
    checks++; if (o_ALU_opcode !== 4'b0000) begin failures++; $display("FAIL rst_opcode got=%0h exp=0", o_ALU_opcode); end
    checks++; if ({o_ex_hold, o_stall_req, o_flg_reg_wr_en, o_flg_jump} !== 4'b0000) begin failures++; $display("FAIL rst_ctrl got=%b exp=0000", {o_ex_hold, o_stall_req, o_flg_reg_wr_en, o_flg_jump}); end
`ifdef PCU_ILLEGAL_TRAP_EN
    checks++; if (o_illegal !== 1'b0) begin failures++; $display("FAIL rst_illegal got=%0b exp=0", o_illegal); end
`endif
    i_reset = 1'b0;
    drive(1'b1, 6'b000000, 1'b0, 6'b011010);
    step();
    checks++; if (o_ALU_opcode !== 4'b1110 || o_ex_hold !== 1'b1) begin failures++; $display("FAIL div_issue got=%0h/%0b exp=e/1", o_ALU_opcode, o_ex_hold); end
    drive(1'b0, 6'b000000, 1'b0, 6'b000000);
    step();
    #2 i_reset = 1'b1;
    #1;
    checks++; if ({o_valid, o_ex_hold, o_stall_req} !== 3'b000 || o_ALU_opcode !== 4'b0000) begin failures++; $display("FAIL rst_abort got=%b/%0h exp=000/0", {o_valid, o_ex_hold, o_stall_req}, o_ALU_opcode); end
    #1 i_reset = 1'b0;
    drive(1'b1, 6'b000000, 1'b0, 6'b100001);
    step();
    checks++; if (o_valid !== 1'b1 || o_ALU_opcode !== 4'b0100) begin failures++; $display("FAIL addu_op got=%0b/%0h exp=1/4", o_valid, o_ALU_opcode); end
    checks++; if (o_flg_ALU_src_a !== 2'b01 || o_flg_ALU_dst !== 2'b01 || o_flg_reg_wr_en !== 1'b1) begin failures++; $display("FAIL addu_fields got=%b/%b/%b exp=01/01/1", o_flg_ALU_src_a, o_flg_ALU_dst, o_flg_reg_wr_en); end
  endtask

  task automatic test_mult();
    drive(1'b1, 6'b000000, 1'b0, 6'b011000);
    step();
    checks++; if (o_ALU_opcode !== 4'b1101 || o_valid !== 1'b1) begin failures++; $display("FAIL mul_issue got=%0h/%0b exp=d/1", o_ALU_opcode, o_valid); end
    checks++; if (o_ex_hold !== 1'b1 || o_stall_req !== 1'b1) begin failures++; $display("FAIL mul_hold1 got=%b%b exp=11", o_ex_hold, o_stall_req); end
    drive(1'b1, 6'b000000, 1'b0, 6'b100001);
    i_hazard_detected = 1'b1;
    step();
    checks++; if (o_ex_hold !== 1'b1 || o_valid !== 1'b1 || o_ALU_opcode !== 4'b1101) begin failures++; $display("FAIL mul_hold2 got=%b/%b/%0h exp=1/1/d", o_ex_hold, o_valid, o_ALU_opcode); end
    step();
    checks++; if (o_ex_hold !== 1'b1 || o_stall_req !== 1'b1) begin failures++; $display("FAIL mul_hold3 got=%b%b exp=11", o_ex_hold, o_stall_req); end
    step();
    checks++; if (o_ex_hold !== 1'b0 || o_stall_req !== 1'b0 || o_ALU_opcode !== 4'b1101 || o_valid !== 1'b1) begin failures++; $display("FAIL mul_exit got=%b%b/%0h/%b exp=00/d/1", o_ex_hold, o_stall_req, o_ALU_opcode, o_valid); end
    i_hazard_detected = 1'b0;
    step();
    checks++; if (o_ALU_opcode !== 4'b0100 || o_valid !== 1'b1) begin failures++; $display("FAIL mul_next got=%0h/%b exp=4/1", o_ALU_opcode, o_valid); end
  endtask

  task automatic test_flush();
    drive(1'b1, 6'b000000, 1'b0, 6'b011010);
    step();
    drive(1'b0, 6'b000000, 1'b0, 6'b000000);
    step();
    checks++; if (o_ex_hold !== 1'b1 || o_ALU_opcode !== 4'b1110) begin failures++; $display("FAIL div_multi got=%b/%0h exp=1/e", o_ex_hold, o_ALU_opcode); end
    i_flush = 1'b1;
    step();
    checks++; if ({o_valid, o_ex_hold, o_stall_req, o_flg_reg_wr_en} !== 4'b0000) begin failures++; $display("FAIL flush_bubble got=%b exp=0000", {o_valid, o_ex_hold, o_stall_req, o_flg_reg_wr_en}); end
    checks++; if (o_ALU_opcode !== 4'b1110) begin failures++; $display("FAIL flush_keep got=%0h exp=e", o_ALU_opcode); end
    i_flush = 1'b0;
    drive(1'b1, 6'b000000, 1'b0, 6'b100001);
    step();
    checks++; if (o_valid !== 1'b1 || o_ALU_opcode !== 4'b0100 || o_ex_hold !== 1'b0) begin failures++; $display("FAIL flush_idle got=%b/%0h/%b exp=1/4/0", o_valid, o_ALU_opcode, o_ex_hold); end
  endtask

  task automatic test_hazard();
    drive(1'b1, 6'b000011, 1'b1, 6'b000000);
    i_hazard_detected = 1'b1;
    step();
    checks++; if (o_flg_mem_wr_en !== 1'b0 || o_valid !== 1'b0) begin failures++; $display("FAIL sw_hazard got=%b/%b exp=0/0", o_flg_mem_wr_en, o_valid); end
    i_hazard_detected = 1'b0;
    step();
    checks++; if (o_flg_mem_wr_en !== 1'b1 || o_flg_reg_wr_en !== 1'b0 || o_valid !== 1'b1) begin failures++; $display("FAIL sw_go got=%b/%b/%b exp=1/0/1", o_flg_mem_wr_en, o_flg_reg_wr_en, o_valid); end
    checks++; if (o_flg_AGU_opcode !== 3'b001 || o_ALU_opcode !== 4'b0011 || o_flg_wb_src !== 1'b1) begin failures++; $display("FAIL sw_fields got=%b/%0h/%b exp=001/3/1", o_flg_AGU_opcode, o_ALU_opcode, o_flg_wb_src); end
    drive(1'b1, 6'b000011, 1'b0, 6'b000000);
    step();
    checks++; if (o_flg_mem_wr_en !== 1'b0 || o_flg_reg_wr_en !== 1'b1 || o_flg_wb_src !== 1'b0) begin failures++; $display("FAIL lw_fields got=%b/%b/%b exp=0/1/0", o_flg_mem_wr_en, o_flg_reg_wr_en, o_flg_wb_src); end
  endtask

  task automatic test_jump();
    drive(1'b1, 6'b110100, 1'b0, 6'b000000);
    step();
    checks++; if (o_flg_ALU_dst !== 2'b11 || o_flg_jump !== 1'b1 || o_flg_reg_wr_en !== 1'b1 || o_flg_AGU_opcode !== 3'b011) begin failures++; $display("FAIL jal got=%b/%b/%b/%b exp=11/1/1/011", o_flg_ALU_dst, o_flg_jump, o_flg_reg_wr_en, o_flg_AGU_opcode); end
    checks++; if (o_flg_AGU_src_addr !== 1'b1 || o_ALU_opcode !== 4'b0011 || o_flg_ALU_src_a !== 2'b00) begin failures++; $display("FAIL jal_src got=%b/%0h/%b exp=1/3/00", o_flg_AGU_src_addr, o_ALU_opcode, o_flg_ALU_src_a); end
    drive(1'b1, 6'b100100, 1'b0, 6'b000000);
    step();
    checks++; if (o_flg_reg_wr_en !== 1'b0 || o_flg_jump !== 1'b1) begin failures++; $display("FAIL j got=%b/%b exp=0/1", o_flg_reg_wr_en, o_flg_jump); end
  endtask

  task automatic test_decode();
    drive(1'b1, 6'b000010, 1'b0, 6'b001111);
    step();
    checks++; if (o_ALU_opcode !== 4'b0011 || o_extend_sign !== 2'b10 || o_flg_ALU_src_a !== 2'b11) begin failures++; $display("FAIL lui got=%0h/%b/%b exp=3/10/11", o_ALU_opcode, o_extend_sign, o_flg_ALU_src_a); end
    drive(1'b1, 6'b000010, 1'b0, 6'b001101);
    step();
    checks++; if (o_ALU_opcode !== 4'b0111 || o_extend_sign !== 2'b00 || o_flg_ALU_dst !== 2'b00) begin failures++; $display("FAIL ori got=%0h/%b/%b exp=7/00/00", o_ALU_opcode, o_extend_sign, o_flg_ALU_dst); end
    drive(1'b1, 6'b000000, 1'b0, 6'b000000);
    step();
    checks++; if (o_ALU_opcode !== 4'b0001 || o_flg_ALU_src_b !== 1'b1) begin failures++; $display("FAIL sll got=%0h/%b exp=1/1", o_ALU_opcode, o_flg_ALU_src_b); end
    drive(1'b1, 6'b000000, 1'b0, 6'b100010);
    step();
    checks++; if (o_ALU_opcode !== 4'b0101 || o_flg_ALU_src_b !== 1'b0) begin failures++; $display("FAIL sub got=%0h/%b exp=5/0", o_ALU_opcode, o_flg_ALU_src_b); end
    drive(1'b1, 6'b101010, 1'b0, 6'b000000);
    step();
    checks++; if (o_ALU_opcode !== 4'b1011 || o_flg_branch !== 1'b1 || o_flg_AGU_opcode !== 3'b010 || o_flg_reg_wr_en !== 1'b0) begin failures++; $display("FAIL beq got=%0h/%b/%b/%b exp=b/1/010/0", o_ALU_opcode, o_flg_branch, o_flg_AGU_opcode, o_flg_reg_wr_en); end
  endtask

  task automatic test_invalid();
    drive(1'b1, 6'b000000, 1'b0, 6'b100010);
    step();
    drive(1'b0, 6'b000000, 1'b0, 6'b100001);
    step();
    checks++; if (o_valid !== 1'b0 || o_flg_reg_wr_en !== 1'b0 || o_ALU_opcode !== 4'b0101) begin failures++; $display("FAIL novalid got=%b/%b/%0h exp=0/0/5", o_valid, o_flg_reg_wr_en, o_ALU_opcode); end
    drive(1'b1, 6'b111111, 1'b0, 6'b000000);
    step();
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL badkey got=%b exp=0", o_valid); end
`ifdef PCU_ILLEGAL_TRAP_EN
    checks++; if (o_illegal !== 1'b1) begin failures++; $display("FAIL illegal_on got=%b exp=1", o_illegal); end
    drive(1'b0, 6'b111111, 1'b0, 6'b000000);
    step();
    checks++; if (o_illegal !== 1'b0) begin failures++; $display("FAIL illegal_off got=%b exp=0", o_illegal); end
`endif
    drive(1'b1, 6'b000000, 1'b0, 6'b111111);
    step();
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL badfunct got=%b exp=0", o_valid); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 6'b000000, 1'b0, 6'b100100);
    step();
    checks++; if (o_ALU_opcode !== 4'b0110 || o_valid !== 1'b1) begin failures++; $display("FAIL and got=%0h/%b exp=6/1", o_ALU_opcode, o_valid); end
    drive(1'b1, 6'b100000, 1'b0, 6'b001000);
    step();
    checks++; if (o_flg_jump !== 1'b1 || o_flg_jmp_trg_reg !== 1'b1 || o_flg_reg_wr_en !== 1'b0 || o_flg_AGU_opcode !== 3'b000) begin failures++; $display("FAIL jr got=%b/%b/%b/%b exp=1/1/0/000", o_flg_jump, o_flg_jmp_trg_reg, o_flg_reg_wr_en, o_flg_AGU_opcode); end
    drive(1'b1, 6'b110000, 1'b0, 6'b001001);
    step();
    checks++; if (o_flg_ALU_src_a !== 2'b00 || o_ALU_opcode !== 4'b0011 || o_flg_ALU_dst !== 2'b01 || o_flg_reg_wr_en !== 1'b1 || o_flg_wb_src !== 1'b1 || o_flg_jmp_trg_reg !== 1'b1) begin failures++; $display("FAIL jalr got=%b/%0h/%b/%b/%b/%b exp=00/3/01/1/1/1", o_flg_ALU_src_a, o_ALU_opcode, o_flg_ALU_dst, o_flg_reg_wr_en, o_flg_wb_src, o_flg_jmp_trg_reg); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_flush();
    test_hazard();
    test_jump();
    test_decode();
    test_invalid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
- Registered, parametrised successor to the single-cycle MIPS decode control.
- Sits at the ID/EX boundary. Decodes the instruction class flags and funct into one control bundle, registered once per cycle.
- Adds a valid bit, bubble insertion on hazard or flush, and an FSM that holds EX for multi-cycle MULT/DIV with a stall request back to IF/ID.

Parameters:
- MUL_LATENCY, 4, EX cycles a MULT occupies (>=1).
- DIV_LATENCY, 8, EX cycles a DIV occupies (>=1).
- CNT_W, $clog2(max(MUL_LATENCY,DIV_LATENCY))+1, hold counter width (derived, not overridden).

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_valid  in  1  ID holds a real instruction.
- i_funct  in  6  R-type funct, or opcode[2:0] in bits [2:0] for immediate ALU ops.
- i_flg_pc_modify, i_flg_link_ret, i_flg_inmediate, i_flg_mem_op, i_flg_mem_type  in  1 each  decoder class flags.
- i_flg_addr_type  in  2  jump address type.
- i_hazard_detected  in  1  load-use stall from the hazard unit.
- i_flush  in  1  taken branch/jump squash.
- o_valid  out  1  bundle in EX is real.
- o_flg_ALU_src_a  out  2  ALU A source select.
- o_flg_ALU_src_b  out  1  ALU B source select.
- o_flg_ALU_dst  out  2  ALU destination register select.
- o_ALU_opcode  out  4  ALU operation code.
- o_flg_AGU_src_addr  out  1  AGU address source select.
- o_flg_AGU_opcode  out  3  AGU operation code.
- o_flg_jump, o_flg_branch, o_flg_reg_wr_en, o_flg_mem_wr_en, o_flg_wb_src, o_flg_jmp_trg_reg  out  1 each  registered control bundle.
- o_extend_sign  out  2  immediate extension mode.
- o_ex_hold  out  1  EX must keep its operands (multi-cycle op in progress).
- o_stall_req  out  1  IF/ID must freeze.

Behaviour:
- Reset:
  - All outputs 0 and FSM in IDLE.
  - Reset asserted mid-MULTI aborts the operation immediately.
- Latency: inputs sampled at edge N appear on outputs after edge N; one cycle, no combinational path from inputs to outputs.
- Class key is {pc_modify, link_ret, addr_type, inmediate, mem_op}:
  - R: 0???0?.
  - JR: 100000.
  - JALR: 110000.
  - LOAD/STORE: 000011.
  - IMM-ALU: 000010.
  - BRANCH: 101010.
  - J/JAL: 1?0100.
- ALU opcodes: SLL 0001, SRL 0000, SRA 0010, ADD 0100, SUB 0101, AND 0110, OR 0111, XOR 1000, NOR 1001, SLT 1010, SADD 1100, PASS 0011, CMP 1011, MUL 1101 (new), DIV 1110 (new).
- Per-class fields:
  - R: src_a=01, dst=01, wr_en=1, wb_src=1.
    - Shifts SLL/SRL/SRA use src_b=1; all other R ops use src_b=0.
    - MULT funct 011000 -> MUL; DIV funct 011010 -> DIV.
  - JR: jump=1, jmp_trg_reg=1, wr_en=0, AGU 0/000.
  - JALR: as JR, plus src_a=00, PASS, dst=01, wr_en=1, wb_src=1.
  - LOAD/STORE: AGU 0/001, PASS, src_a=01, dst=00, mem_wr_en=mem_type, wr_en=~mem_type, wb_src=mem_type.
  - IMM-ALU: src_a=11, src_b=0, dst=00, wr_en=1, wb_src=1.
    - Funct 000=SADD, 100=AND, 101=OR, 110=XOR, 010=SLT, all with extend 00.
    - Funct 111=PASS with extend 10 (LUI).
  - BRANCH: CMP, src_a=01, branch=1, AGU 1/010, wr_en=0.
  - J/JAL: src_a=00, dst=11, PASS, AGU 1/011, jump=1, wr_en=link_ret, wb_src=1.
- Bubble: o_valid=0, and reg_wr_en, mem_wr_en, jump, branch all 0; remaining fields keep their previous values.
- Priority each edge: reset > flush > MULTI hold > hazard > (i_valid=0) > decode.
  - Flush: bubble and force IDLE, even while in MULTI.
  - Hazard in IDLE: bubble.
  - i_valid=0: bubble.
  - Unknown class key or funct: bubble.
- FSM:
  - IDLE: on decoding MUL/DIV, register the bundle, load cnt = LATENCY-1 and go to MULTI if cnt != 0; otherwise stay in IDLE.
  - MULTI: bundle frozen (o_valid stays 1); o_ex_hold=1; o_stall_req=1; inputs ignored except flush; cnt decrements each cycle.
  - MULTI exit: at the cycle where cnt==1, the next edge returns to IDLE.
  - Net effect: o_ex_hold is high for LATENCY-1 cycles after the issue cycle.
- Outputs during MULTI:
  - o_stall_req is registered and equals (state==MULTI).
  - While o_stall_req=1, the i_hazard_detected value is ignored.

Optional Feature:
- Macro: PCU_ILLEGAL_TRAP_EN.
- Defined: adds port o_illegal (out, 1).
  - o_illegal pulses 1 for exactly one cycle, aligned with the bubble, when i_valid=1 and the key or funct is unknown.
  - Reset value 0; suppressed by flush, hazard and MULTI.
- Undefined: the port is absent; unknown encodings produce silent bubbles.

Test Plan:
- Reset mid-DIV, then release; ADDU funct 100001 with R key -> next cycle o_valid=1, ALU_opcode=0100, src_a=01, dst=01, reg_wr_en=1.
- MULT (funct 011000), MUL_LATENCY=4 -> opcode 1101; o_ex_hold and o_stall_req high 3 cycles; following ADDU emitted exactly 4 cycles after MULT.
- DIV issued, i_flush at 2nd MULTI cycle -> next cycle o_valid=0, o_ex_hold=0, o_stall_req=0, FSM IDLE.
- SW (key 000011, mem_type=1) with i_hazard_detected=1 -> mem_wr_en=0, o_valid=0; next cycle without hazard -> mem_wr_en=1, reg_wr_en=0.
- JAL (key 110100) -> dst=11, jump=1, reg_wr_en=1, AGU opcode 011; J (key 100100) -> reg_wr_en=0.
- With PCU_ILLEGAL_TRAP_EN, key 111111 with i_valid=1 -> o_illegal=1 for one cycle, o_valid=0; same key with i_valid=0 -> o_illegal=0.
